raiz_tmp_hist: RTL and testbench
================================

# raiz_tmp_hist

Parametrised history and convergence register for the iterative square-root datapath in the calculator. It captures successive root estimates `Resultado` on `LD_TMP` into a DEPTH-deep shift history, counts iterations and compares each new estimate against the history. It flags convergence, integer 2-cycle oscillation or iteration timeout, so the root controller can stop iterating without its own comparators.

## Interface
Parameters:
- `WIDTH`, 16: width of each estimate.
- `DEPTH`, 4: history entries; minimum 2.
- `MAX_ITER`, 32: captures allowed before timeout; minimum 2.
- `TOL`, 0: maximum absolute difference between consecutive estimates counted as converged.

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `LD`  in  1  synchronous clear; starts a new computation.
- `LD_TMP`  in  1  capture strobe for `Resultado`.
- `Resultado`  in  WIDTH  current estimate R.
- `TMP_out`  out  WIDTH  newest captured estimate (hist[0]).
- `TMP_prev`  out  WIDTH  previous estimate (hist[1]).
- `Hist_flat`  out  DEPTH*WIDTH  hist[i] at bits [i*WIDTH +: WIDTH].
- `Diff`  out  WIDTH  combinational |Resultado − TMP_out|.
- `Iter_cnt`  out  $clog2(MAX_ITER+1)  captures since the last `LD`.
- `Busy`  out  1  high in RUN.
- `Converged`, `Oscillating`, `Timeout`  out  1 each  registered terminal flags.

## Operation
- States:
  - IDLE: after reset.
  - RUN: accepting captures.
  - CONV, OSC, TOUT: terminal states.
- Reset (`RST_N`=0, asynchronous):
  - all hist entries, `Iter_cnt` and all flags go to 0.
  - state goes to IDLE.
- `LD`=1 (any state):
  - clears hist and `Iter_cnt` to 0 and drops all flags.
  - moves to RUN.
  - has priority over a simultaneous `LD_TMP`, which is dropped.
- `LD_TMP`=1 in RUN, `LD`=0:
  - hist[i] <= hist[i−1] for i ≥ 1; hist[0] <= `Resultado`; the oldest entry is discarded.
  - `Iter_cnt` increments.
  - The evaluation below uses the pre-shift hist and pre-increment `Iter_cnt`. First match wins:
    1. `Iter_cnt` ≥ 1 and |`Resultado` − hist[0]| ≤ TOL → CONV.
    2. `Iter_cnt` ≥ 2 and `Resultado` == hist[1] and `Resultado` != hist[0] → OSC.
    3. `Iter_cnt`+1 == MAX_ITER → TOUT.
    4. Otherwise stay in RUN.
- Precedence is convergence > oscillation > timeout; all three can be true on the same capture.
- `LD_TMP` in IDLE, CONV, OSC or TOUT is ignored: history and count hold.
- Terminal states hold until `LD` or reset.
- Flag outputs:
  - `Converged` = (state==CONV); `Oscillating` = (state==OSC); `Timeout` = (state==TOUT).
  - At most one flag is high at a time.
  - `Busy` = (state==RUN).
- Arithmetic:
  - `Diff` is unsigned magnitude, computed as a larger-minus-smaller select; no wrap.
  - The TOL comparison is unsigned on WIDTH bits.
  - `Iter_cnt` never exceeds MAX_ITER.

## Timing
- Capture latency is 1 cycle: hist, `Iter_cnt` and flags reflect a capture immediately after the capturing edge.
- `Diff` is combinational from `Resultado` and `TMP_out`, with zero latency.
- `LD` takes effect at the next edge. `Busy` is high from the cycle after `LD`.
- Back-to-back `LD_TMP` (every cycle) is supported; each edge is one capture.
- Asserting `RST_N` mid-RUN clears everything asynchronously. After release, the block sits in IDLE until `LD`.
- Outputs are glitch-free registers, except `Diff`.

## Test plan
- **Reset values:** assert `RST_N`=0 mid-run → all outputs 0 and `Busy`=0 without waiting for a clock edge. After release, `LD_TMP` pulses leave `Iter_cnt`=0.
- **Convergence (WIDTH=16, TOL=0):** `LD`, then capture 100, 50, 26, 15, 13, 13.
  - `Converged`=1 after the 6th capture; `Iter_cnt`=6.
  - `TMP_out`=13, `TMP_prev`=13; `Hist_flat` = {26,15,13,13} (hist[3]..hist[0]).
  - A further capture of 99 changes nothing.
- **Oscillation:** `LD`, then capture 10, 9, 10.
  - `Oscillating`=1, `Converged`=0, `Iter_cnt`=3.
  - With TOL=1, the same sequence gives `Converged` after the 2nd capture instead.
- **Timeout (MAX_ITER=8):** capture 8 strictly distinct, non-repeating values.
  - `Timeout`=1 exactly after the 8th capture; `Iter_cnt`=8; `Busy`=0.
- **Simultaneous LD and LD_TMP:** during RUN with `Iter_cnt`=3, assert both for one cycle.
  - Result: hist all 0, `Iter_cnt`=0, RUN, no capture.
  - `Diff` equals `Resultado` while `TMP_out`=0.
- **Diff magnitude:** `TMP_out`=5 with `Resultado`=3 → `Diff`=2; with `Resultado`=0xFFFF → `Diff`=0xFFFA.

Source files
------------

// File: rtl/raiz_tmp_hist.sv
// Purpose: history shift register and convergence/oscillation/timeout detector for the iterative square-root loop.
// Latency: captures, Iter_cnt and flags update on the capturing edge; Diff is combinational.
// Backpressure: none; LD_TMP is accepted every cycle in RUN and ignored elsewhere, LD always wins.
module raiz_tmp_hist #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 4,
    parameter int MAX_ITER = 32,
    parameter int TOL      = 0
) (
    input  logic                             CLK,
    input  logic                             RST_N,
    input  logic                             LD,
    input  logic                             LD_TMP,
    input  logic [WIDTH-1:0]                 Resultado,
    output logic [WIDTH-1:0]                 TMP_out,
    output logic [WIDTH-1:0]                 TMP_prev,
    output logic [DEPTH*WIDTH-1:0]           Hist_flat,
    output logic [WIDTH-1:0]                 Diff,
    output logic [$clog2(MAX_ITER+1)-1:0]    Iter_cnt,
    output logic                             Busy,
    output logic                             Converged,
    output logic                             Oscillating,
    output logic                             Timeout
);

    localparam int                CNT_W = $clog2(MAX_ITER + 1);
    localparam logic [WIDTH-1:0]  TOL_W = WIDTH'(TOL);
    // Count value seen on the capture that reaches MAX_ITER.
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(MAX_ITER - 1);
    localparam logic [CNT_W-1:0]  TWO   = CNT_W'(2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_CONV,
        S_OSC,
        S_TOUT
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   hist [DEPTH];
    logic [CNT_W-1:0]   cnt_q;
    logic               clr, cap;
    logic               busy_q, conv_q, osc_q, tout_q;

    // Magnitude as larger-minus-smaller so the result never wraps.
    assign Diff = (Resultado >= hist[0]) ? (Resultado - hist[0]) : (hist[0] - Resultado);

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state: LD restarts from anywhere; a capture in RUN is judged against pre-shift history.
    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        cap     = 1'b0;
        if (LD) begin
            clr     = 1'b1;
            state_d = S_RUN;
        end else if (state_q == S_RUN && LD_TMP) begin
            cap = 1'b1;
            if (cnt_q != '0 && Diff <= TOL_W)
                state_d = S_CONV;
            else if (cnt_q >= TWO && Resultado == hist[1] && Resultado != hist[0])
                state_d = S_OSC;
            else if (cnt_q == LAST)
                state_d = S_TOUT;
        end
    end

    // History shift and capture counter.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
            cnt_q <= '0;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
            cnt_q <= '0;
        end else if (cap) begin
            for (int i = DEPTH - 1; i > 0; i--) hist[i] <= hist[i-1];
            hist[0] <= Resultado;
            cnt_q   <= cnt_q + 1'b1;
        end
    end

    // Flags registered from the next-state decode so each output is a plain flop.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            busy_q <= 1'b0;
            conv_q <= 1'b0;
            osc_q  <= 1'b0;
            tout_q <= 1'b0;
        end else begin
            busy_q <= (state_d == S_RUN);
            conv_q <= (state_d == S_CONV);
            osc_q  <= (state_d == S_OSC);
            tout_q <= (state_d == S_TOUT);
        end
    end

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_flat
            assign Hist_flat[g*WIDTH +: WIDTH] = hist[g];
        end
    endgenerate

    assign TMP_out     = hist[0];
    assign TMP_prev    = hist[1];
    assign Iter_cnt    = cnt_q;
    assign Busy        = busy_q;
    assign Converged   = conv_q;
    assign Oscillating = osc_q;
    assign Timeout     = tout_q;

endmodule

// File: tb/tb_raiz_tmp_hist.sv
// Directed bench for raiz_tmp_hist: two instances share stimulus, one with TOL=0 and one with TOL=1.
// Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
// All expected values below are hand-derived from the block's behaviour.
module tb_raiz_tmp_hist;

    localparam int W = 16;
    localparam int D = 4;
    localparam int M = 8;
    localparam int CW = $clog2(M + 1);

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          LD;
    logic          LD_TMP;
    logic [W-1:0]  Resultado;

    logic [W-1:0]   tmp0, prev0, diff0, tmp1, prev1, diff1;
    logic [D*W-1:0] hist0, hist1;
    logic [CW-1:0]  iter0, iter1;
    logic           busy0, conv0, osc0, tout0, busy1, conv1, osc1, tout1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    raiz_tmp_hist #(.WIDTH(W), .DEPTH(D), .MAX_ITER(M), .TOL(0)) dut0 (
        .CLK(CLK), .RST_N(RST_N), .LD(LD), .LD_TMP(LD_TMP), .Resultado(Resultado),
        .TMP_out(tmp0), .TMP_prev(prev0), .Hist_flat(hist0), .Diff(diff0),
        .Iter_cnt(iter0), .Busy(busy0), .Converged(conv0), .Oscillating(osc0), .Timeout(tout0)
    );

    raiz_tmp_hist #(.WIDTH(W), .DEPTH(D), .MAX_ITER(M), .TOL(1)) dut1 (
        .CLK(CLK), .RST_N(RST_N), .LD(LD), .LD_TMP(LD_TMP), .Resultado(Resultado),
        .TMP_out(tmp1), .TMP_prev(prev1), .Hist_flat(hist1), .Diff(diff1),
        .Iter_cnt(iter1), .Busy(busy1), .Converged(conv1), .Oscillating(osc1), .Timeout(tout1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_ld();
        @(negedge CLK);
        LD = 1'b1;
        @(posedge CLK);
        #1;
        LD = 1'b0;
    endtask

    task automatic do_cap(input logic [W-1:0] v);
        @(negedge CLK);
        Resultado = v;
        LD_TMP    = 1'b1;
        @(posedge CLK);
        #1;
        LD_TMP = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N = 1'b0; LD = 1'b0; LD_TMP = 1'b0; Resultado = '0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_iter", iter0, 0);
        check("rst_busy", busy0, 0);
        check("rst_tmp",  tmp0, 0);
        check("rst_flags", {conv0, osc0, tout0}, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        do_cap(16'd7);
        do_cap(16'd9);
        check("idle_ignore_iter", iter0, 0);
        check("idle_ignore_tmp",  tmp0, 0);
        check("idle_busy", busy0, 0);

        // Convergence: 100,50,26,15,13,13
        do_ld();
        check("ld_busy", busy0, 1);
        check("ld_iter", iter0, 0);
        do_cap(16'd100); do_cap(16'd50); do_cap(16'd26); do_cap(16'd15); do_cap(16'd13);
        check("conv_pre", conv0, 0);
        check("conv_pre_iter", iter0, 5);
        do_cap(16'd13);
        check("conv_flag", conv0, 1);
        check("conv_iter", iter0, 6);
        check("conv_tmp",  tmp0, 13);
        check("conv_prev", prev0, 13);
        check("conv_hist", hist0, {16'd26, 16'd15, 16'd13, 16'd13});
        check("conv_busy", busy0, 0);
        check("conv_others", {osc0, tout0}, 0);
        do_cap(16'd99);
        check("conv_hold_iter", iter0, 6);
        check("conv_hold_tmp",  tmp0, 13);
        check("conv_hold_flag", conv0, 1);

        // Oscillation: 10,9,10; TOL=1 instance converges on the 2nd capture
        do_ld();
        check("ld_clears_conv", conv0, 0);
        do_cap(16'd10); do_cap(16'd9);
        check("osc_tol1_conv", conv1, 1);
        check("osc_tol1_iter", iter1, 2);
        check("osc_tol0_mid", {conv0, osc0}, 0);
        do_cap(16'd10);
        check("osc_flag", osc0, 1);
        check("osc_conv", conv0, 0);
        check("osc_iter", iter0, 3);
        check("osc_tol1_hold", {conv1, osc1, 8'(iter1)}, {1'b1, 1'b0, 8'd2});

        // Timeout at MAX_ITER=8
        do_ld();
        for (int i = 1; i <= 7; i++) do_cap(W'(i * 3));
        check("tout_pre", {tout0, busy0}, 2'b01);
        check("tout_pre_iter", iter0, 7);
        do_cap(16'd24);
        check("tout_flag", tout0, 1);
        check("tout_iter", iter0, 8);
        check("tout_busy", busy0, 0);
        check("tout_others", {conv0, osc0}, 0);

        // Simultaneous LD and LD_TMP: LD wins, no capture
        do_ld();
        do_cap(16'd100); do_cap(16'd200); do_cap(16'd300);
        check("sim_pre_iter", iter0, 3);
        @(negedge CLK);
        LD = 1'b1; LD_TMP = 1'b1; Resultado = 16'd77;
        @(posedge CLK);
        #1;
        LD = 1'b0; LD_TMP = 1'b0;
        check("sim_hist", hist0, 0);
        check("sim_iter", iter0, 0);
        check("sim_busy", busy0, 1);
        check("sim_diff", diff0, 77);

        // Diff magnitude
        do_cap(16'd5);
        check("diff_tmp", tmp0, 5);
        Resultado = 16'd3;
        #1;
        check("diff_small", diff0, 2);
        Resultado = 16'hFFFF;
        #1;
        check("diff_big", diff0, 16'hFFFA);

        // Asynchronous reset mid-run
        do_ld();
        do_cap(16'd40);
        check("ar_pre_tmp", tmp0, 40);
        #2;
        RST_N = 1'b0;
        #1;
        check("ar_tmp",  tmp0, 0);
        check("ar_hist", hist0, 0);
        check("ar_iter", iter0, 0);
        check("ar_busy", busy0, 0);
        check("ar_flags", {conv0, osc0, tout0}, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        do_cap(16'd11);
        do_cap(16'd12);
        check("ar_after_iter", iter0, 0);
        check("ar_after_busy", busy0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
